// File: rtl/ps2_defs.sv
// Shared scan-code constants, prefix FSM encoding and FIFO default for the
// PS/2 key decoder.
package ps2_defs;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_ascii_lut.sv
// Scan-code set 2 to ASCII table (US layout), unshifted and shifted values.
// Codes without a printable mapping return 8'h00.
module ps2_ascii_lut (
    input  logic [7:0] scan,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] lo;
    logic [7:0] hi;

    always_comb begin
        lo = 8'h00;
        hi = 8'h00;
        case (scan)
            8'h1C: begin lo = 8'h61; hi = 8'h41; end
            8'h32: begin lo = 8'h62; hi = 8'h42; end
            8'h21: begin lo = 8'h63; hi = 8'h43; end
            8'h23: begin lo = 8'h64; hi = 8'h44; end
            8'h24: begin lo = 8'h65; hi = 8'h45; end
            8'h2B: begin lo = 8'h66; hi = 8'h46; end
            8'h34: begin lo = 8'h67; hi = 8'h47; end
            8'h33: begin lo = 8'h68; hi = 8'h48; end
            8'h43: begin lo = 8'h69; hi = 8'h49; end
            8'h3B: begin lo = 8'h6A; hi = 8'h4A; end
            8'h42: begin lo = 8'h6B; hi = 8'h4B; end
            8'h4B: begin lo = 8'h6C; hi = 8'h4C; end
            8'h3A: begin lo = 8'h6D; hi = 8'h4D; end
            8'h31: begin lo = 8'h6E; hi = 8'h4E; end
            8'h44: begin lo = 8'h6F; hi = 8'h4F; end
            8'h4D: begin lo = 8'h70; hi = 8'h50; end
            8'h15: begin lo = 8'h71; hi = 8'h51; end
            8'h2D: begin lo = 8'h72; hi = 8'h52; end
            8'h1B: begin lo = 8'h73; hi = 8'h53; end
            8'h2C: begin lo = 8'h74; hi = 8'h54; end
            8'h3C: begin lo = 8'h75; hi = 8'h55; end
            8'h2A: begin lo = 8'h76; hi = 8'h56; end
            8'h1D: begin lo = 8'h77; hi = 8'h57; end
            8'h22: begin lo = 8'h78; hi = 8'h58; end
            8'h35: begin lo = 8'h79; hi = 8'h59; end
            8'h1A: begin lo = 8'h7A; hi = 8'h5A; end
            // Digit row: shifted values are the US symbols above each digit
            8'h16: begin lo = 8'h31; hi = 8'h21; end
            8'h1E: begin lo = 8'h32; hi = 8'h40; end
            8'h26: begin lo = 8'h33; hi = 8'h23; end
            8'h25: begin lo = 8'h34; hi = 8'h24; end
            8'h2E: begin lo = 8'h35; hi = 8'h25; end
            8'h36: begin lo = 8'h36; hi = 8'h5E; end
            8'h3D: begin lo = 8'h37; hi = 8'h26; end
            8'h3E: begin lo = 8'h38; hi = 8'h2A; end
            8'h46: begin lo = 8'h39; hi = 8'h28; end
            8'h45: begin lo = 8'h30; hi = 8'h29; end
            8'h0E: begin lo = 8'h60; hi = 8'h7E; end
            8'h4E: begin lo = 8'h2D; hi = 8'h5F; end
            8'h55: begin lo = 8'h3D; hi = 8'h2B; end
            8'h54: begin lo = 8'h5B; hi = 8'h7B; end
            8'h5B: begin lo = 8'h5D; hi = 8'h7D; end
            8'h5D: begin lo = 8'h5C; hi = 8'h7C; end
            8'h4C: begin lo = 8'h3B; hi = 8'h3A; end
            8'h52: begin lo = 8'h27; hi = 8'h22; end
            8'h41: begin lo = 8'h2C; hi = 8'h3C; end
            8'h49: begin lo = 8'h2E; hi = 8'h3E; end
            8'h4A: begin lo = 8'h2F; hi = 8'h3F; end
            8'h29: begin lo = 8'h20; hi = 8'h20; end
            8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
            8'h66: begin lo = 8'h08; hi = 8'h08; end
            default: begin lo = 8'h00; hi = 8'h00; end
        endcase
        ascii = shift ? hi : lo;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: prefix FSM tracks E0/F0, shift keys are held as
// flags, and mapped make codes are queued as ASCII in a FWFT FIFO.
module ps2_key_decoder
    import ps2_defs::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       key_ready,
    output logic       key_valid,
    output logic [7:0] key_ascii,
    output logic       shift_active,
    output logic       overflow,
    output logic [1:0] fsm_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ps2_state_t state;
    logic       lshift;
    logic       rshift;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [7:0] lut_ascii;
    logic       is_make;
    logic       push_req;
    logic       pop;
    logic       full;
    logic       do_push;

    ps2_ascii_lut u_lut (
        .scan  (rx_data),
        .shift (shift_active),
        .ascii (lut_ascii)
    );

    assign shift_active = lshift | rshift;
    assign fsm_state    = state;

    // A make code is any non-prefix byte arriving while no prefix is pending.
    assign is_make  = rx_done_tick && (state == ST_IDLE) &&
                      (rx_data != PS2_EXT) && (rx_data != PS2_BRK);
    assign push_req = is_make && (rx_data != PS2_LSHIFT) &&
                      (rx_data != PS2_RSHIFT) && (lut_ascii != 8'h00);

    assign key_valid = (count != '0);
    assign key_ascii = mem[rd_ptr];
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = key_valid && key_ready;
    assign do_push   = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            lshift <= 1'b0;
            rshift <= 1'b0;
        end else if (rx_done_tick) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == PS2_EXT) begin
                        state <= ST_EXT;
                    end else if (rx_data == PS2_BRK) begin
                        state <= ST_BRK;
                    end else begin
                        if (rx_data == PS2_LSHIFT) lshift <= 1'b1;
                        if (rx_data == PS2_RSHIFT) rshift <= 1'b1;
                    end
                end
                ST_EXT: begin
                    state <= (rx_data == PS2_BRK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_BRK: begin
                    if (rx_data == PS2_LSHIFT) lshift <= 1'b0;
                    if (rx_data == PS2_RSHIFT) rshift <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= lut_ascii;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !do_push) begin
                count <= count - 1'b1;
            end
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: scan-byte sequences with hand-computed
// ASCII events, shift state, FIFO fill/overflow and reset behaviour.
module tb_ps2_key_decoder;

    logic       clk;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       key_ready;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic       shift_active;
    logic       overflow;
    logic [1:0] fsm_state;

    int n_vec;
    int n_err;

    ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .key_ready    (key_ready),
        .key_valid    (key_valid),
        .key_ascii    (key_ascii),
        .shift_active (shift_active),
        .overflow     (overflow),
        .fsm_state    (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(key_valid), 32'd1);
        check({tag, "_ascii"}, 32'(key_ascii), 32'(exp));
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        key_ready    = 1'b0;
        step();
        step();
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_shift", 32'(shift_active), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        reset = 1'b1;
        step();

        // 'a' visible one cycle after the tick; break produces nothing
        send_byte(8'h1C);
        check("a_latency_valid", 32'(key_valid), 32'd1);
        check("a_latency_ascii", 32'(key_ascii), 32'h61);
        send_byte(8'hF0);
        check("brk_state", 32'(fsm_state), 32'd2);
        send_byte(8'h1C);
        pop_expect("a_pop", 8'h61);
        check("a_only_one", 32'(key_valid), 32'd0);
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        check("ready_empty", 32'(key_valid), 32'd0);

        // left shift make/break around letters
        send_byte(8'h12);
        check("lshift_on", 32'(shift_active), 32'd1);
        check("lshift_no_evt", 32'(key_valid), 32'd0);
        send_byte(8'h1C);
        check("lshift_held", 32'(shift_active), 32'd1);
        send_byte(8'hF0);
        send_byte(8'h12);
        check("lshift_off", 32'(shift_active), 32'd0);
        send_byte(8'h1C);
        pop_expect("A_pop", 8'h41);
        pop_expect("a2_pop", 8'h61);
        check("shift_seq_empty", 32'(key_valid), 32'd0);

        // right shift: 'Q', shifted digit '!', shifted '/' -> '?'
        send_byte(8'h59);
        check("rshift_on", 32'(shift_active), 32'd1);
        send_byte(8'h15);
        send_byte(8'h16);
        send_byte(8'h4A);
        send_byte(8'hF0);
        send_byte(8'h59);
        check("rshift_off", 32'(shift_active), 32'd0);
        pop_expect("Q_pop", 8'h51);
        pop_expect("bang_pop", 8'h21);
        pop_expect("quest_pop", 8'h3F);

        // extended make and break discarded, then '1'
        send_byte(8'hE0);
        check("ext_state", 32'(fsm_state), 32'd1);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        check("extbrk_state", 32'(fsm_state), 32'd3);
        send_byte(8'h75);
        check("ext_no_evt", 32'(key_valid), 32'd0);
        check("ext_idle", 32'(fsm_state), 32'd0);
        send_byte(8'h16);
        pop_expect("one_pop", 8'h31);

        // unmapped code, typematic repeat, enter, backspace
        send_byte(8'h05);
        check("unmapped", 32'(key_valid), 32'd0);
        send_byte(8'h5A);
        send_byte(8'h5A);
        send_byte(8'h66);
        pop_expect("enter1", 8'h0D);
        pop_expect("enter2", 8'h0D);
        pop_expect("bksp", 8'h08);
        check("misc_empty", 32'(key_valid), 32'd0);

        // overflow: six makes into a four-deep FIFO
        send_byte(8'h1C);
        send_byte(8'h32);
        send_byte(8'h21);
        send_byte(8'h23);
        check("full_no_ovf", 32'(overflow), 32'd0);
        send_byte(8'h24);
        send_byte(8'h2B);
        check("ovf_set", 32'(overflow), 32'd1);
        pop_expect("ovf_a", 8'h61);
        pop_expect("ovf_b", 8'h62);
        pop_expect("ovf_c", 8'h63);
        pop_expect("ovf_d", 8'h64);
        check("ovf_drained", 32'(key_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // full with simultaneous push and pop
        do_reset();
        check("ovf_cleared", 32'(overflow), 32'd0);
        send_byte(8'h1C);
        send_byte(8'h32);
        send_byte(8'h21);
        send_byte(8'h23);
        rx_data      = 8'h29;
        rx_done_tick = 1'b1;
        key_ready    = 1'b1;
        step();
        rx_done_tick = 1'b0;
        key_ready    = 1'b0;
        check("pp_no_ovf", 32'(overflow), 32'd0);
        pop_expect("pp_b", 8'h62);
        pop_expect("pp_c", 8'h63);
        pop_expect("pp_d", 8'h64);
        pop_expect("pp_space", 8'h20);
        check("pp_empty", 32'(key_valid), 32'd0);

        // reset mid-prefix with a coincident tick
        send_byte(8'h12);
        send_byte(8'h1C);
        send_byte(8'hF0);
        reset        = 1'b0;
        rx_data      = 8'h1C;
        rx_done_tick = 1'b1;
        step();
        check("mid_rst_valid", 32'(key_valid), 32'd0);
        check("mid_rst_shift", 32'(shift_active), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_state", 32'(fsm_state), 32'd0);
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        step();
        check("post_rst_empty", 32'(key_valid), 32'd0);
        send_byte(8'h1C);
        pop_expect("post_rst_a", 8'h61);
        check("post_rst_done", 32'(key_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
